lcd_hd44780_sequencer: RTL and testbench

//  Hardware sequencer for the HD44780 character LCD on the DE2-115 (4-bit data bus, RS, RW, E).

---
 rtl/lcd_hd44780_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_lcd_hd44780_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_sequencer.sv
// rtl/lcd_hd44780_sequencer.sv - HD44780 4-bit init/command sequencer with E timing
module lcd_hd44780_sequencer #(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned INIT_WAIT      = 205000,
    parameter int unsigned SETUP_CYCLES   = 3,
    parameter int unsigned E_PULSE_CYCLES = 25,
    parameter int unsigned SHORT_WAIT     = 2000,
    parameter int unsigned LONG_WAIT      = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       init_done,
    output logic [3:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAXV = max2(max2(max2(POWERUP_CYCLES, INIT_WAIT), max2(SETUP_CYCLES, E_PULSE_CYCLES)),
                                        max2(SHORT_WAIT, LONG_WAIT));
    localparam int CNT_W = $clog2(MAXV + 1);

    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_POWERUP, S_LOAD, S_SETUP, S_EHIGH, S_ELOW, S_WAIT, S_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [3:0]       step_q, step_d;
    logic [7:0]       byte_q, byte_d;
    logic             rs_q, rs_d;
    logic             nib_only_q, nib_only_d;
    logic             second_q, second_d;
    logic [3:0]       lcd_data_q, lcd_data_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_e_q, lcd_e_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_POWERUP;
            cnt_q      <= '0;
            wait_q     <= '0;
            step_q     <= '0;
            byte_q     <= '0;
            rs_q       <= 1'b0;
            nib_only_q <= 1'b0;
            second_q   <= 1'b0;
            lcd_data_q <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_e_q    <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            step_q     <= step_d;
            byte_q     <= byte_d;
            rs_q       <= rs_d;
            nib_only_q <= nib_only_d;
            second_q   <= second_d;
            lcd_data_q <= lcd_data_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_e_q    <= lcd_e_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        wait_d     = wait_q;
        step_d     = step_q;
        byte_d     = byte_q;
        rs_d       = rs_q;
        nib_only_d = nib_only_q;
        second_d   = second_q;
        lcd_data_d = lcd_data_q;
        lcd_rs_d   = lcd_rs_q;
        done_d     = done_q;

        case (state_q)
            S_POWERUP: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d    = '0;
                second_d = 1'b0;
                state_d  = S_SETUP;
                if (!done_q) begin
                    // Init ROM: three 0x3 wake-ups, switch to 4-bit, then configure.
                    rs_d       = 1'b0;
                    nib_only_d = (step_q < 4'd4);
                    wait_d     = CNT_W'(SHORT_WAIT);
                    case (step_q)
                        4'd0, 4'd1, 4'd2: begin byte_d = 8'h30; wait_d = CNT_W'(INIT_WAIT); end
                        4'd3:             byte_d = 8'h20;
                        4'd4:             byte_d = 8'h28;
                        4'd5:             byte_d = 8'h08;
                        4'd6:             begin byte_d = 8'h01; wait_d = CNT_W'(LONG_WAIT); end
                        4'd7:             byte_d = 8'h06;
                        default:          byte_d = 8'h0C;
                    endcase
                end else begin
                    // Clear display / return home need the long execution time.
                    wait_d = (!rs_q && byte_q[7:2] == 6'd0 && byte_q[1:0] != 2'd0)
                           ? CNT_W'(LONG_WAIT) : CNT_W'(SHORT_WAIT);
                end
                lcd_data_d = byte_d[7:4];
                lcd_rs_d   = rs_d;
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EHIGH;
                end
            end
            S_EHIGH: begin
                if (cnt_q == E_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ELOW;
                end
            end
            S_ELOW: begin
                if (cnt_q == E_LAST) begin
                    cnt_d = '0;
                    if (!second_q && !nib_only_q) begin
                        second_d   = 1'b1;
                        lcd_data_d = byte_q[3:0];
                        state_d    = S_SETUP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    if (done_q) begin
                        state_d = S_IDLE;
                    end else if (step_q == 4'd8) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (cmd_valid && ready_q) begin
                    byte_d     = cmd_data;
                    rs_d       = cmd_rs;
                    nib_only_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_POWERUP;
            end
        endcase

        lcd_e_d = (state_d == S_EHIGH);
        ready_d = (state_d == S_IDLE);
    end

    assign cmd_ready = ready_q;
    assign init_done = done_q;
    assign lcd_data  = lcd_data_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = lcd_e_q;

endmodule

// File: tb/tb_lcd_hd44780_sequencer.sv
// tb/tb_lcd_hd44780_sequencer.sv - self-checking bench for lcd_hd44780_sequencer
module tb_lcd_hd44780_sequencer;

    localparam int P  = 100;
    localparam int IW = 50;
    localparam int S  = 2;
    localparam int E  = 4;
    localparam int SH = 20;
    localparam int LW = 80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       init_done;
    logic [3:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;

    lcd_hd44780_sequencer #(
        .POWERUP_CYCLES(P), .INIT_WAIT(IW), .SETUP_CYCLES(S),
        .E_PULSE_CYCLES(E), .SHORT_WAIT(SH), .LONG_WAIT(LW)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .init_done(init_done), .lcd_data(lcd_data),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [4:0] q_pulse[$];
    int         first_rise = -1;
    int         rise_cyc = 0;
    logic [3:0] rise_data = 4'h0;
    logic       prev_e = 1'b0;
    int         bad_ready = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rules: the post-byte wait and the full transfer length.
    function automatic int exp_wait(input logic rs, input logic [7:0] d);
        return (!rs && d < 8'd4 && d != 8'd0) ? LW : SH;
    endfunction

    function automatic int exp_busy(input logic rs, input logic [7:0] d);
        return 1 + 2 * (S + 2 * E) + exp_wait(rs, d);
    endfunction

    // E-pulse monitor: records {rs,data} at each rising E and checks width/hold.
    always @(negedge clk) begin
        if (rst) begin
            prev_e = 1'b0;
        end else begin
            if (cmd_ready && !init_done) bad_ready++;
            if (lcd_e && !prev_e) begin
                if (q_pulse.size() == 0) first_rise = cyc;
                q_pulse.push_back({lcd_rs, lcd_data});
                rise_cyc  = cyc;
                rise_data = lcd_data;
            end
            if (!lcd_e && prev_e) begin
                chk("e_width", 32'(cyc - rise_cyc), 32'(E));
                chk("e_data_hold", 32'(lcd_data), 32'(rise_data));
            end
            prev_e = lcd_e;
        end
    end

    task automatic wait_init(input string tag, input bit garbage);
        logic [7:0] rom[9];
        int         exp_q[$];
        int         t_init;
        int         rel;
        int         n;
        rom = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
        t_init = P;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(int'(rom[i][7:4]));
            if (i >= 4) exp_q.push_back(int'(rom[i][3:0]));
            t_init += 1 + ((i < 4) ? 1 : 2) * (S + 2 * E) + ((i < 3) ? IW : exp_wait(1'b0, rom[i]));
        end
        rel = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (garbage) begin
                cmd_data = 8'($urandom);
                cmd_rs   = 1'($urandom);
            end
        end while (!init_done && n < 3000);
        chk({tag, " done_cycle"}, 32'(n), 32'(t_init));
        chk({tag, " ready_at_done"}, 32'(cmd_ready), 32'd1);
        chk({tag, " first_e_rise"}, 32'(first_rise - rel), 32'(P + S + 1));
        chk({tag, " pulse_count"}, 32'(q_pulse.size()), 32'(exp_q.size()));
        if (q_pulse.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++)
                chk({tag, " init_nibble"}, 32'(q_pulse[i]), 32'(exp_q[i]));
        end
        q_pulse.delete();
    endtask

    task automatic xfer(input logic rs, input logic [7:0] d, input bit hold, input string tag);
        int n;
        q_pulse.delete();
        cmd_valid = 1'b1;
        cmd_rs    = rs;
        cmd_data  = d;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            n++;
            if (hold) begin
                cmd_data = 8'($urandom);
                cmd_rs   = 1'($urandom);
            end
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 32'(n), 32'(exp_busy(rs, d)));
        chk({tag, " pulse_count"}, 32'(q_pulse.size()), 32'd2);
        if (q_pulse.size() == 2) begin
            chk({tag, " hi_nibble"}, 32'(q_pulse[0]), 32'({rs, d[7:4]}));
            chk({tag, " lo_nibble"}, 32'(q_pulse[1]), 32'({rs, d[3:0]}));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic       r;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({lcd_e, lcd_data, lcd_rs, lcd_rw, cmd_ready, init_done}), 32'd0);
        q_pulse.delete();
        rst = 1'b0;
        wait_init("init1", 1'b0);

        xfer(1'b1, 8'h41, 1'b0, "data_41");
        xfer(1'b0, 8'h01, 1'b0, "clear");
        xfer(1'b0, 8'h00, 1'b0, "cmd_00");
        xfer(1'b1, 8'h01, 1'b0, "data_01");
        xfer(1'b0, 8'h02, 1'b0, "home");
        xfer(1'b0, 8'h03, 1'b0, "cmd_03");
        xfer(1'b0, 8'h04, 1'b0, "cmd_04");

        for (int i = 0; i < 10; i++) begin
            r = 1'($urandom);
            d = (i % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            xfer(r, d, 1'b0, "random");
        end

        xfer(1'b0, 8'h01, 1'b1, "hold_a");
        xfer(1'b1, 8'h55, 1'b1, "hold_b");
        xfer(1'($urandom), 8'($urandom), 1'b0, "hold_c");

        // Reset while the second nibble's E is high.
        q_pulse.delete();
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = 8'h5A;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (q_pulse.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_e_high", 32'(lcd_e), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({lcd_e, lcd_data, lcd_rs, lcd_rw, cmd_ready, init_done}), 32'd0);
        repeat (3) @(negedge clk);
        chk("held_reset_outputs", 32'({lcd_e, lcd_data, lcd_rs, cmd_ready, init_done}), 32'd0);
        q_pulse.delete();
        first_rise = -1;
        cmd_valid  = 1'b1;
        cmd_rs     = 1'b0;
        cmd_data   = 8'($urandom);
        rst = 1'b0;
        wait_init("init2", 1'b1);
        xfer(1'($urandom), 8'($urandom), 1'b0, "after_init2");

        chk("ready_before_init", 32'(bad_ready), 32'd0);
        chk("lcd_rw_tied", 32'(lcd_rw), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
